// File: rtl/hv_seq_ctrl_if.sv
// Stream handshake monitor bundle for hv_seq_ctrl: S_AXIS (src) and M_AXIS (dst)
// valid/ready/last as seen on the stream clock. The sequencer only observes these.
interface hv_seq_ctrl_if;
  logic src_valid;
  logic src_ready;
  logic src_last;
  logic dst_valid;
  logic dst_ready;
  logic dst_last;

  modport master (
    output src_valid, src_ready, src_last,
    output dst_valid, dst_ready, dst_last
  );

  modport slave (
    input src_valid, src_ready, src_last,
    input dst_valid, dst_ready, dst_last
  );
endinterface

// File: rtl/hv_seq_ctrl.sv
// Run sequencer: latches job geometry, walks item-memory generation (matw), holds run until
// the final output beat. Optional RUN watchdog enabled by defining HV_SEQ_WDOG_EN.
module hv_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  hv_seq_ctrl_if.slave axis,
  input  logic        start,
  input  logic        abort,
  input  logic [19:0] cfg_ngram,
  input  logic [19:0] cfg_blocks,
  input  logic [15:0] cfg_items,
  output logic        matw,
  output logic [15:0] mat_a,
  output logic        run,
  output logic [19:0] addr_i,
  output logic [19:0] addr_j,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] beat_cnt
);

  typedef enum logic [1:0] {IDLE, GEN, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] items;
  logic        src_done;

  logic src_hs, dst_hs, src_last_hs, dst_last_hs, wdog_hit;
  assign src_hs      = axis.src_valid & axis.src_ready;
  assign dst_hs      = axis.dst_valid & axis.dst_ready;
  assign src_last_hs = src_hs & axis.src_last;
  assign dst_last_hs = dst_hs & axis.dst_last;

`ifdef HV_SEQ_WDOG_EN
  logic [15:0] idle_cnt;
  assign wdog_hit = (idle_cnt == 16'(TIMEOUT_CYC - 1)) & ~src_hs & ~dst_hs;
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state    <= IDLE;
      items    <= '0;
      src_done <= 1'b0;
      matw     <= 1'b0;
      mat_a    <= '0;
      run      <= 1'b0;
      addr_i   <= '0;
      addr_j   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      beat_cnt <= '0;
`ifdef HV_SEQ_WDOG_EN
      idle_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort beats a simultaneous start
          if (start && !abort) begin
            addr_j   <= cfg_ngram;
            addr_i   <= cfg_blocks;
            items    <= cfg_items;
            err      <= 1'b0;
            beat_cnt <= '0;
            mat_a    <= '0;
            src_done <= 1'b0;
            matw     <= 1'b1;
            busy     <= 1'b1;
            state    <= GEN;
          end
        end
        GEN: begin
          if (abort) begin
            matw  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else if (mat_a == items) begin
            // mat_a holds at the last address; no wrap even for items = 16'hFFFF
            matw  <= 1'b0;
            run   <= 1'b1;
            state <= RUN;
`ifdef HV_SEQ_WDOG_EN
            idle_cnt <= '0;
`endif
          end else begin
            mat_a <= mat_a + 16'd1;
          end
        end
        RUN: begin
          if (abort) begin
            run   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            if (src_last_hs) src_done <= 1'b1;
            if (dst_hs) beat_cnt <= beat_cnt + 32'd1;
            if (dst_last_hs) begin
              // a src_last in the same cycle counts as already seen
              if (!src_done && !src_last_hs) err <= 1'b1;
              run   <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (wdog_hit) begin
              run   <= 1'b0;
              busy  <= 1'b0;
              err   <= 1'b1;
              state <= IDLE;
            end
`ifdef HV_SEQ_WDOG_EN
            if (src_hs || dst_hs) idle_cnt <= '0;
            else                  idle_cnt <= idle_cnt + 16'd1;
`endif
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          matw  <= 1'b0;
          run   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_seq_ctrl.sv
// Self-checking bench for hv_seq_ctrl: randomized handshakes against a job-level model
// (GEN length = items+1, beat count = dst handshakes, err = dst_last before src_last).
module tb_hv_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [19:0] cfg_ngram = '0;
  logic [19:0] cfg_blocks = '0;
  logic [15:0] cfg_items = '0;
  logic        matw, run, busy, done, err;
  logic [15:0] mat_a;
  logic [19:0] addr_i, addr_j;
  logic [31:0] beat_cnt;

  int n_checks = 0;
  int n_fail = 0;

  hv_seq_ctrl_if bus ();

  always #5 clk = ~clk;

  hv_seq_ctrl #(.TIMEOUT_CYC(50)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .axis(bus.slave),
    .start(start), .abort(abort),
    .cfg_ngram(cfg_ngram), .cfg_blocks(cfg_blocks), .cfg_items(cfg_items),
    .matw(matw), .mat_a(mat_a), .run(run), .addr_i(addr_i), .addr_j(addr_j),
    .busy(busy), .done(done), .err(err), .beat_cnt(beat_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.src_valid = 0; bus.src_ready = 0; bus.src_last = 0;
    bus.dst_valid = 0; bus.dst_ready = 0; bus.dst_last = 0;
  endtask

  // pulse start, then count cycles with matw high (bounded)
  task automatic start_job(input logic [15:0] items, input logic [19:0] ng, input logic [19:0] bl,
                           output int gen_len);
    cfg_items = items; cfg_ngram = ng; cfg_blocks = bl;
    start = 1; step(); start = 0;
    gen_len = 0;
    while (matw === 1'b1 && gen_len < 70000) begin
      gen_len++;
      step();
    end
  endtask

  // one handshake on src or dst with random stalls; forced through after 20 tries
  task automatic beat(input bit is_src, input bit last);
    bit v, r, hs;
    int tries;
    hs = 0; tries = 0;
    while (!hs) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      if (tries >= 20) begin v = 1; r = 1; end
      if (is_src) begin bus.src_valid = v; bus.src_ready = r; bus.src_last = last; end
      else        begin bus.dst_valid = v; bus.dst_ready = r; bus.dst_last = last; end
      hs = v & r;
      tries++;
      step();
    end
    clear_bus();
  endtask

  task automatic both_last();
    bus.src_valid = 1; bus.src_ready = 1; bus.src_last = 1;
    bus.dst_valid = 1; bus.dst_ready = 1; bus.dst_last = 1;
    step();
    clear_bus();
  endtask

  task automatic test_reset();
    rst_n = 0;
    step(); step();
    n_checks++;
    if ({matw, run, busy, done, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {matw, run, busy, done, err});
    end
    n_checks++;
    if ({mat_a, addr_i, addr_j, beat_cnt} !== 88'd0) begin
      n_fail++; $display("FAIL reset_regs: mat_a=%0d addr_i=%0d addr_j=%0d beat_cnt=%0d want 0",
                         mat_a, addr_i, addr_j, beat_cnt);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_gen();
    int k;
    cfg_items = 16'd99; cfg_ngram = 20'd2; cfg_blocks = 20'd7;
    start = 1; step(); start = 0;
    k = 0;
    while (matw === 1'b1 && k < 200) begin
      n_checks++;
      if (mat_a !== 16'(k)) begin
        n_fail++; $display("FAIL gen_mat_a: got %0d want %0d", mat_a, k);
      end
      if (run !== 1'b0) begin
        n_fail++; $display("FAIL gen_run_low: run=%b during matw at k=%0d", run, k);
      end
      k++;
      step();
    end
    n_checks++;
    if (k != 100) begin n_fail++; $display("FAIL gen_len: got %0d want 100", k); end
    n_checks++;
    if (run !== 1'b1) begin n_fail++; $display("FAIL gen_to_run: run=%b want 1", run); end
    n_checks++;
    if (mat_a !== 16'd99) begin n_fail++; $display("FAIL gen_hold: mat_a=%0d want 99", mat_a); end
    n_checks++;
    if (addr_j !== 20'd2 || addr_i !== 20'd7) begin
      n_fail++; $display("FAIL gen_cfg: addr_j=%0d addr_i=%0d want 2 7", addr_j, addr_i);
    end
    abort = 1; step(); abort = 0;
  endtask

  task automatic test_full_job();
    int gl;
    logic [15:0] it;
    it = 16'($urandom_range(0, 15));
    start_job(it, 20'd1, 20'd4, gl);
    n_checks++;
    if (gl != int'(it) + 1) begin n_fail++; $display("FAIL full_gen_len: got %0d want %0d", gl, int'(it) + 1); end
    for (int i = 0; i < 8; i++) beat(1'b1, i == 7);
    for (int i = 0; i < 8; i++) beat(1'b0, i == 7);
    n_checks++;
    if (done !== 1'b1 || run !== 1'b0) begin
      n_fail++; $display("FAIL full_done: done=%b run=%b want 1 0", done, run);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL full_idle: done=%b busy=%b want 0 0", done, busy);
    end
    n_checks++;
    if (err !== 1'b0 || beat_cnt !== 32'd8) begin
      n_fail++; $display("FAIL full_result: err=%b beat_cnt=%0d want 0 8", err, beat_cnt);
    end
  endtask

  task automatic test_early_dst();
    int gl;
    start_job(16'd3, 20'd0, 20'd0, gl);
    for (int i = 0; i < 3; i++) beat(1'b0, i == 2);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL early_dst: done=%b err=%b want 1 1", done, err);
    end
    step();
    start_job(16'd2, 20'd0, 20'd0, gl);
    n_checks++;
    if (err !== 1'b0 || run !== 1'b1) begin
      n_fail++; $display("FAIL early_restart: err=%b run=%b want 0 1", err, run);
    end
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    step(); step();
  endtask

  task automatic test_same_cycle();
    int gl;
    start_job(16'd5, 20'd1, 20'd3, gl);
    beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    cfg_blocks = 20'hABCDE; cfg_ngram = 20'h12345;
    start = 1; step(); start = 0;
    n_checks++;
    if (busy !== 1'b1 || run !== 1'b1 || matw !== 1'b0 || addr_i !== 20'd3 || addr_j !== 20'd1) begin
      n_fail++; $display("FAIL start_in_run: busy=%b run=%b matw=%b addr_i=%0d addr_j=%0d want 1 1 0 3 1",
                         busy, run, matw, addr_i, addr_j);
    end
    both_last();
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || beat_cnt !== 32'd3) begin
      n_fail++; $display("FAIL same_cycle: done=%b err=%b beat_cnt=%0d want 1 0 3", done, err, beat_cnt);
    end
    step();
  endtask

  task automatic test_abort_gen();
    cfg_items = 16'd50; cfg_ngram = 20'd0; cfg_blocks = 20'd0;
    start = 1; abort = 1; step(); start = 0; abort = 0;
    n_checks++;
    if (busy !== 1'b0 || matw !== 1'b0) begin
      n_fail++; $display("FAIL start_abort_idle: busy=%b matw=%b want 0 0", busy, matw);
    end
    start = 1; step(); start = 0;
    repeat (10) step();
    abort = 1; step(); abort = 0;
    n_checks++;
    if (busy !== 1'b0 || matw !== 1'b0 || err !== 1'b1 || mat_a !== 16'd10 || run !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_gen: busy=%b matw=%b err=%b mat_a=%0d run=%b done=%b want 0 0 1 10 0 0",
                         busy, matw, err, mat_a, run, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int gl;
    start_job(16'd2, 20'd5, 20'd9, gl);
    beat(1'b0, 1'b0);
    n_checks++;
    if (beat_cnt !== 32'd1 || addr_i !== 20'd9 || run !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: beat_cnt=%0d addr_i=%0d run=%b want 1 9 1", beat_cnt, addr_i, run);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({matw, run, busy, done, err, mat_a, addr_i, addr_j, beat_cnt} !== 93'd0) begin
      n_fail++; $display("FAIL reset_mid_run: run=%b busy=%b addr_i=%0d beat_cnt=%0d want all 0",
                         run, busy, addr_i, beat_cnt);
    end
    step();
    rst_n = 1;
    step();
  endtask

  // model: GEN lasts items+1; beat_cnt = dst handshakes; err iff dst_last precedes src_last
  task automatic test_random();
    int gl, nsrc, ndst, mode, exp_beats;
    bit exp_err;
    logic [15:0] it;
    for (int j = 0; j < 8; j++) begin
      it = 16'($urandom_range(0, 30));
      nsrc = $urandom_range(1, 5);
      ndst = $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      start_job(it, 20'($urandom), 20'($urandom), gl);
      n_checks++;
      if (gl != int'(it) + 1) begin n_fail++; $display("FAIL rnd_gen_len[%0d]: got %0d want %0d", j, gl, int'(it) + 1); end
      exp_beats = ndst;
      exp_err = (mode == 1);
      case (mode)
        0: begin
          for (int i = 0; i < nsrc; i++) beat(1'b1, i == nsrc - 1);
          for (int i = 0; i < ndst; i++) beat(1'b0, i == ndst - 1);
        end
        1: begin
          for (int i = 0; i < nsrc - 1; i++) beat(1'b1, 1'b0);
          for (int i = 0; i < ndst; i++) beat(1'b0, i == ndst - 1);
        end
        default: begin
          for (int i = 0; i < nsrc - 1; i++) beat(1'b1, 1'b0);
          for (int i = 0; i < ndst - 1; i++) beat(1'b0, 1'b0);
          both_last();
        end
      endcase
      n_checks++;
      if (done !== 1'b1 || err !== exp_err || beat_cnt !== 32'(exp_beats)) begin
        n_fail++; $display("FAIL rnd_job[%0d] mode %0d: done=%b err=%b beat_cnt=%0d want 1 %b %0d",
                           j, mode, done, err, beat_cnt, exp_err, exp_beats);
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL rnd_idle[%0d]: busy=%b done=%b want 0 0", j, busy, done);
      end
    end
  endtask

  task automatic test_watchdog();
    int gl, rc;
    bit saw_done;
    start_job(16'd4, 20'd0, 20'd0, gl);
`ifdef HV_SEQ_WDOG_EN
    rc = 0; saw_done = 0;
    while (run === 1'b1 && rc < 2000) begin
      rc++;
      step();
      if (done === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (rc != 50 || err !== 1'b1 || busy !== 1'b0 || saw_done) begin
      n_fail++; $display("FAIL watchdog: run_cycles=%0d err=%b busy=%b done_seen=%b want 50 1 0 0",
                         rc, err, busy, saw_done);
    end
`else
    rc = 0; saw_done = 0;
    repeat (1000) begin
      step();
      if (run === 1'b1) rc++;
      if (done === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (rc != 1000 || busy !== 1'b1 || err !== 1'b0 || saw_done) begin
      n_fail++; $display("FAIL no_watchdog: run_cycles=%0d busy=%b err=%b done_seen=%b want 1000 1 0 0",
                         rc, busy, err, saw_done);
    end
    abort = 1; step(); abort = 0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || run !== 1'b0) begin
      n_fail++; $display("FAIL abort_run: err=%b busy=%b run=%b want 1 0 0", err, busy, run);
    end
`endif
  endtask

  initial begin
    clear_bus();
    test_reset();
    test_gen();
    test_full_job();
    test_early_dst();
    test_same_cycle();
    test_abort_gen();
    test_reset_mid_run();
    test_random();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hv_seq_ctrl.md
# hv_seq_ctrl

Run sequencer for the hypervector processing pipeline. On one start command it latches the job configuration (n-gram depth, block count, item-memory size) and drives the `matw` item-memory generation phase. It then holds `run` while the stream datapath consumes input and emits results, and reports completion or error. It replaces the fixed `addr_i`/`addr_j`/`random_num` registers and the software-timed `matw`/`run` toggling in the top level, and sits between the AXI-Lite register file and the `src_ctrl`/`exe_ctrl`/`out_ctrl`/`core` datapath, all on the stream clock.

## Interface
- `TIMEOUT_CYC`, 65535: idle-cycle limit for the watchdog (only used with `HV_SEQ_WDOG_EN`).
- `AXIS_ACLK`  in  1  stream clock; all logic on its rising edge.
- `AXIS_ARESETN`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle job start command (from the register file).
- `abort`  in  1  one-cycle abort command.
- `cfg_ngram`  in  20  n-gram depth minus 1, latched to `addr_j`.
- `cfg_blocks`  in  20  output blocks minus 1, latched to `addr_i`.
- `cfg_items`  in  16  last item-memory address, i.e. item count minus 1.
- `src_valid`, `src_ready`, `src_last`  in  1 each  monitor of the S_AXIS handshake.
- `dst_valid`, `dst_ready`, `dst_last`  in  1 each  monitor of the M_AXIS handshake.
- `matw`  out  1  item-memory write phase, to `core` and `xorshift`.
- `mat_a`  out  16  item-memory write address.
- `run`  out  1  datapath enable; the datapath uses `~run` as its reset.
- `addr_i`, `addr_j`  out  20 each  latched job geometry, to `exe_ctrl`/`out_ctrl`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky error flag, cleared by an accepted `start`.
- `beat_cnt`  out  32  count of accepted dst beats in the current job.

## Operation
- States: IDLE, GEN, RUN, DONE. The state register and every output are registered.
- **IDLE.** If `start` is high and `abort` is low:
  - latch `addr_j`, `addr_i` and the internal `items` register from the config inputs;
  - clear `err`, `beat_cnt`, `mat_a` and `src_done`;
  - go to GEN.
- **IDLE, `start` and `abort` together.** `abort` wins; the start is dropped.
- **GEN.**
  - `matw` = 1.
  - `mat_a` increments by 1 per cycle, starting at 0.
  - When `mat_a == items`, the next state is RUN, `matw` drops and `mat_a` holds. `mat_a` never wraps.
  - GEN therefore lasts `items`+1 cycles; `cfg_items`=0 gives 1 cycle and `cfg_items`=65535 gives 65536 cycles.
- **RUN.**
  - `run` = 1.
  - A source handshake with `src_last` (`src_valid & src_ready & src_last`) sets `src_done`.
  - Each dst handshake (`dst_valid & dst_ready`) increments `beat_cnt` (32-bit, wraps modulo 2^32).
  - A dst handshake with `dst_last` moves the block to DONE.
  - If that `dst_last` arrives while `src_done` is still 0, `err` is set and the block still goes to DONE.
  - If `src_last` and `dst_last` handshake in the same cycle, both are taken, `src_done` is treated as already set, and no error is raised.
- **DONE.** `run` = 0 and `done` = 1 for exactly one cycle; then IDLE.
- **`start` while not IDLE.** Ignored; no state or config change.
- **`abort` in GEN, RUN or DONE.**
  - Next cycle: IDLE, with `matw`, `run` and `done` at 0.
  - `err` is set if the abort came in GEN or RUN.
  - `addr_i`, `addr_j` and `beat_cnt` hold their values.
- `addr_i`/`addr_j` hold while not IDLE; config input changes after start have no effect.

## Timing
- **Reset.** Asynchronous assertion: state = IDLE; `matw`, `run`, `busy`, `done`, `err` = 0; `mat_a`, `addr_i`, `addr_j`, `beat_cnt` = 0. Deassertion is synchronised to `AXIS_ACLK` by the reset source.
- **Reset mid-job.** Immediate return to the reset values; no `done` pulse.
- **Start latency.** `start` sampled at edge T gives `busy`=`matw`=1 and `mat_a`=0 after edge T; `mat_a`=k after edge T+k.
- **GEN to RUN.** After the edge where `mat_a==items` is sampled, `matw`=0 and `run`=1, with no gap cycle.
- **Completion latency.** The `dst_last` handshake at edge E gives `done`=1, `run`=0 after E, and `busy`=0 after E+1.
- **Flow control.** This block never drives ready/valid; it only observes handshakes, so it adds no backpressure.

## Configuration
- `HV_SEQ_WDOG_EN` defined:
  - A 16-bit idle counter runs in RUN and clears on any src or dst handshake.
  - When it reaches `TIMEOUT_CYC`, the block sets `err` and goes to IDLE next cycle, with `run`=0 and no `done` pulse.
- `HV_SEQ_WDOG_EN` undefined: no counter; RUN waits indefinitely for `dst_last`.

## Test plan
- Reset then start with `cfg_items`=99, `cfg_ngram`=2, `cfg_blocks`=7: `matw` high for exactly 100 cycles with `mat_a` 0..99; `run` rises the cycle `matw` falls; `addr_j`=2, `addr_i`=7.
- Full job: 8 src beats with `src_last` on the 8th, then 8 dst beats with `dst_last` on the 8th. Expect `beat_cnt`=8, one `done` pulse, `err`=0, `busy`=0 one cycle after `done`.
- `dst_last` before `src_last`: `err`=1, `done` pulses; the next `start` clears `err`.
- `src_last` and `dst_last` handshakes in the same cycle: `err`=0. A `start` during RUN is ignored, and `addr_i` is unchanged after `cfg_blocks` changes.
- `abort` on GEN cycle 10: IDLE next cycle, `matw`=0, `err`=1, `mat_a`=10 held. Separately, `AXIS_ARESETN` low mid-RUN: all outputs 0 immediately.
- With `HV_SEQ_WDOG_EN` and `TIMEOUT_CYC`=50: stall in RUN with no handshakes, giving `err`=1 and IDLE after 50 idle cycles. Without the macro, RUN is still held after 1000 cycles.
